ym_chain_mixer: RTL and testbench
=================================

Name: ym_chain_mixer

Overview:
Parametrised, time-multiplexed stereo mixer for a chain of CH_COUNT YM2612 cores. It replaces the combinational sum tree between the FM cores and the delta-sigma modulators.
- Per-chip gain and pan registers, loaded through a config write port.
- One multiply-accumulate per clk_jt cycle, triggered by the chip-0 sample strobe.
- Saturated OUT_W-bit stereo result with clip flags and a dropped-strobe counter.

Parameters:
CH_COUNT, 5, number of chips mixed (1..31)
IN_W, 16, signed sample width per chip
OUT_W, 16, signed output width
GAIN_W, 8, unsigned gain width; unity = 2^(GAIN_W-1)

Ports:
clk_jt  in  1  clock
rst  in  1  reset; synchronous, active-high; clock is clk_jt
snd_sample  in  1  sample strobe (one clk_jt wide pulse)
snd_left_bus  in  CH_COUNT*IN_W  chip i left sample at bits [i*IN_W +: IN_W]
snd_right_bus  in  CH_COUNT*IN_W  chip i right sample, same packing
cfg_we  in  1  config write strobe
cfg_addr  in  6  bit5=0: gain reg of chip [4:0]; bit5=1: pan reg of chip [4:0]
cfg_data  in  GAIN_W  write data (pan uses bits 1:0)
out_left  out  OUT_W  mixed left sample
out_right  out  OUT_W  mixed right sample
out_valid  out  1  one-cycle pulse when out_* update
clip_l  out  1  left saturated in current out_* sample
clip_r  out  1  right saturated in current out_* sample
busy  out  1  accumulation in progress
drop_cnt  out  8  strobes ignored while busy, saturating

Behaviour:
- Reset values:
  - out_left, out_right = 0; out_valid, clip_l, clip_r, busy = 0; drop_cnt = 0.
  - All gains = 2^(GAIN_W-1). All pans = 2'b11 (bit0 = left enable, bit1 = right enable).
  - State = IDLE.
- Config writes: applied at the clk_jt edge where cfg_we=1. Writes with cfg_addr[4:0] >= CH_COUNT are ignored. Writes are accepted in any state.
- States: IDLE -> ACC -> SAT -> IDLE.
- IDLE:
  - On snd_sample=1: snapshot both buses into internal registers, clear both accumulators, set idx=0, go to ACC. busy=1 from the next cycle.
- ACC (exactly CH_COUNT cycles):
  - Each cycle, for chip idx: acc_l += pan[idx][0] ? sample_l[idx]*gain[idx] : 0. Same for acc_r using pan bit1.
  - Then idx++. Leave for SAT after idx = CH_COUNT-1.
  - Gain and pan are read in the cycle their chip is accumulated. A write landing earlier in the same sequence affects that sample; a write after that chip is accumulated does not.
- Arithmetic:
  - Product = signed sample × zero-extended unsigned gain.
  - Accumulator width = IN_W + GAIN_W + clog2(CH_COUNT) + 1, so no intermediate overflow is possible.
- SAT (one cycle):
  - scaled = acc >>> (GAIN_W-1), arithmetic shift (floor toward -inf).
  - If scaled > 2^(OUT_W-1)-1, output max and set clip; if scaled < -2^(OUT_W-1), output min and set clip; else output scaled and clear clip.
  - Register out_*, clip_*, pulse out_valid, go to IDLE.
- Latency: out_valid is high in the cycle CH_COUNT+2 edges after the edge that sampled snd_sample (7 for CH_COUNT=5). busy=0 in that cycle.
- Outputs hold between updates.
- snd_sample while busy (ACC or SAT): ignored; drop_cnt++ (saturates at 255). snd_sample coincident with out_valid (state IDLE) is accepted normally.
- Reset mid-operation: abort immediately; all state and registers return to reset values; no out_valid is issued.

Test Plan:
1. Reset, CH_COUNT=5, all chips L=1000, R=-1000, strobe -> out_valid exactly 7 cycles later; out_left=5000, out_right=-5000; clip_l=clip_r=0; busy high cycles 1-6.
2. All chips L=0x7FFF, R=0x8000 at unity, strobe -> out_left=0x7FFF, clip_l=1; out_right=0x8000, clip_r=1. Next strobe with all inputs 0 -> outputs 0, clips 0.
3. Gain:
   - chip0 gain 0x40, L=1000, others 0 -> 500.
   - gain 0xFF, L=128 -> 255.
   - gain 0x40, L=-1 -> -1 (floor).
   - Write chip1 gain 0x00 after chip1 accumulated -> unaffected this sample, zero next sample.
4. Pan: chip2 pan=2'b01, L=R=2000, others 0 -> left 2000, right 0. Write to cfg_addr 6'h05 (out of range) -> no register changes.
5. Second strobe 3 cycles after first -> single out_valid, drop_cnt=1. 300 such overlaps -> drop_cnt=255.
6. rst asserted at cycle 3 of ACC -> next cycle busy=0, out_*=0, gains=0x80, no out_valid. Fresh strobe gives a correct result.

Source files
------------

// File: rtl/ym_chain_mixer_if.sv
// ym_chain_mixer_if -- signal bundle between the YM2612 chain and the mixer.
//
// Carries the per-chip sample buses with their strobe, the config write port
// and the mixed stereo result with its status flags.
//   master : the chain/controller side (drives samples and config)
//   slave  : the mixer side (drives out_*, clip_*, busy, drop_cnt)
interface ym_chain_mixer_if #(
    parameter int CH_COUNT = 5,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int GAIN_W   = 8
);
    logic                       snd_sample;
    logic [CH_COUNT*IN_W-1:0]   snd_left_bus;
    logic [CH_COUNT*IN_W-1:0]   snd_right_bus;
    logic                       cfg_we;
    logic [5:0]                 cfg_addr;
    logic [GAIN_W-1:0]          cfg_data;
    logic signed [OUT_W-1:0]    out_left;
    logic signed [OUT_W-1:0]    out_right;
    logic                       out_valid;
    logic                       clip_l;
    logic                       clip_r;
    logic                       busy;
    logic [7:0]                 drop_cnt;

    modport master (
        output snd_sample, snd_left_bus, snd_right_bus,
        output cfg_we, cfg_addr, cfg_data,
        input  out_left, out_right, out_valid, clip_l, clip_r, busy, drop_cnt
    );

    modport slave (
        input  snd_sample, snd_left_bus, snd_right_bus,
        input  cfg_we, cfg_addr, cfg_data,
        output out_left, out_right, out_valid, clip_l, clip_r, busy, drop_cnt
    );
endinterface

// File: rtl/ym_chain_mixer.sv
// ym_chain_mixer -- time-multiplexed stereo mixer for a chain of YM2612 cores.
//
// One multiply-accumulate per clk_jt cycle replaces the combinational sum tree.
// A chip-0 sample strobe snapshots every chip's stereo sample, the chips are
// then weighted by their gain and pan enables one per cycle, and the sums are
// scaled back by unity gain and saturated to OUT_W bits.
//
// Ports:
//   clk_jt : clock
//   rst    : synchronous, active-high reset
//   mix    : slave side of ym_chain_mixer_if
//            snd_sample / snd_left_bus / snd_right_bus  sample input
//            cfg_we / cfg_addr / cfg_data               gain (addr[5]=0) and
//                                                       pan (addr[5]=1) writes
//            out_left / out_right / out_valid           mixed result
//            clip_l / clip_r                            saturation flags
//            busy / drop_cnt                            status
module ym_chain_mixer #(
    parameter int CH_COUNT = 5,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int GAIN_W   = 8
) (
    input  logic            clk_jt,
    input  logic            rst,
    ym_chain_mixer_if.slave mix
);
    localparam int CNT_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int ACC_W  = IN_W + GAIN_W + $clog2(CH_COUNT) + 1;
    localparam int PROD_W = IN_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_SAT  = 2'd2;

    // Signed sample times zero-extended unsigned gain; a disabled pan side
    // contributes nothing.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [IN_W-1:0] smp,
        input logic [GAIN_W-1:0]      gain,
        input logic                   en
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(smp) * PROD_W'($signed({1'b0, gain}));
        return en ? ACC_W'(prod) : '0;
    endfunction

    // Drop the unity-gain fraction (floor) and clamp to OUT_W; the MSB of the
    // result is the clip flag.
    function automatic logic [OUT_W:0] saturate(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] scaled;
        scaled = acc >>> (GAIN_W-1);
        if (scaled > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        else if (scaled < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        else
            return {1'b0, scaled[OUT_W-1:0]};
    endfunction

    logic [1:0]              state;
    logic [CNT_W-1:0]        idx;
    logic [7:0]              drop_cnt;
    logic [GAIN_W-1:0]       gain_reg [CH_COUNT];
    logic [1:0]              pan_reg  [CH_COUNT];

    logic signed [IN_W-1:0]  snap_l_p0 [CH_COUNT];
    logic signed [IN_W-1:0]  snap_r_p0 [CH_COUNT];
    logic signed [ACC_W-1:0] acc_l_p0;
    logic signed [ACC_W-1:0] acc_r_p0;

    logic signed [IN_W-1:0]  cur_l;
    logic signed [IN_W-1:0]  cur_r;
    logic [GAIN_W-1:0]       cur_gain;
    logic [1:0]              cur_pan;
    logic signed [ACC_W-1:0] term_l;
    logic signed [ACC_W-1:0] term_r;

    logic signed [OUT_W-1:0] sat_l_p1;
    logic signed [OUT_W-1:0] sat_r_p1;
    logic                    clip_l_p1;
    logic                    clip_r_p1;
    logic                    vld_p1;

    logic signed [OUT_W-1:0] out_l_p2;
    logic signed [OUT_W-1:0] out_r_p2;
    logic                    clip_l_p2;
    logic                    clip_r_p2;
    logic                    vld_p2;

    // Gain and pan are taken from the live registers of the chip being
    // accumulated, so a config write lands on the next chip visit only.
    always_comb begin
        cur_l    = '0;
        cur_r    = '0;
        cur_gain = '0;
        cur_pan  = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (idx == CNT_W'(i)) begin
                cur_l    = snap_l_p0[i];
                cur_r    = snap_r_p0[i];
                cur_gain = gain_reg[i];
                cur_pan  = pan_reg[i];
            end
        end
        term_l = mac_term(cur_l, cur_gain, cur_pan[0]);
        term_r = mac_term(cur_r, cur_gain, cur_pan[1]);
    end

    // ---- stage p0: snapshot and accumulate (data path, no reset) ----
    always_ff @(posedge clk_jt) begin
        if (state == S_IDLE && mix.snd_sample) begin
            for (int i = 0; i < CH_COUNT; i++) begin
                snap_l_p0[i] <= $signed(mix.snd_left_bus[i*IN_W +: IN_W]);
                snap_r_p0[i] <= $signed(mix.snd_right_bus[i*IN_W +: IN_W]);
            end
            acc_l_p0 <= '0;
            acc_r_p0 <= '0;
        end else if (state == S_ACC) begin
            acc_l_p0 <= acc_l_p0 + term_l;
            acc_r_p0 <= acc_r_p0 + term_r;
        end

        // ---- stage p1: scale and saturate ----
        if (state == S_SAT) begin
            {clip_l_p1, sat_l_p1} <= saturate(acc_l_p0);
            {clip_r_p1, sat_r_p1} <= saturate(acc_r_p0);
        end
    end

    // Control, configuration and the output register stage.
    always_ff @(posedge clk_jt) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            drop_cnt  <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_l_p2  <= '0;
            out_r_p2  <= '0;
            clip_l_p2 <= 1'b0;
            clip_r_p2 <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) begin
                gain_reg[i] <= GAIN_UNITY;
                pan_reg[i]  <= 2'b11;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (mix.snd_sample) begin
                        state <= S_ACC;
                        idx   <= '0;
                    end
                end
                S_ACC: begin
                    if (idx == CNT_W'(CH_COUNT-1))
                        state <= S_SAT;
                    else
                        idx <= idx + CNT_W'(1);
                end
                S_SAT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (mix.snd_sample && state != S_IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            // Out-of-range chip addresses simply match no register.
            for (int i = 0; i < CH_COUNT; i++) begin
                if (mix.cfg_we && mix.cfg_addr[4:0] == 5'(i)) begin
                    if (mix.cfg_addr[5])
                        pan_reg[i] <= mix.cfg_data[1:0];
                    else
                        gain_reg[i] <= mix.cfg_data;
                end
            end

            vld_p1 <= (state == S_SAT);

            // ---- stage p2: output register ----
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_l_p2  <= sat_l_p1;
                out_r_p2  <= sat_r_p1;
                clip_l_p2 <= clip_l_p1;
                clip_r_p2 <= clip_r_p1;
            end
        end
    end

    assign mix.out_left  = out_l_p2;
    assign mix.out_right = out_r_p2;
    assign mix.out_valid = vld_p2;
    assign mix.clip_l    = clip_l_p2;
    assign mix.clip_r    = clip_r_p2;
    assign mix.busy      = (state != S_IDLE);
    assign mix.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_ym_chain_mixer.sv
// tb_ym_chain_mixer -- self-checking bench for ym_chain_mixer (CH_COUNT=5).
// Expected values come from a sum-of-products model over the chips, using
// the gain/pan registers as the bench believes them to be.
module tb_ym_chain_mixer;
    localparam int CH     = 5;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int GAIN_W = 8;
    localparam longint UNITY = 128;

    logic clk_jt = 1'b0;
    logic rst;
    always #5 clk_jt = ~clk_jt;

    ym_chain_mixer_if #(.CH_COUNT(CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) mix();

    ym_chain_mixer #(.CH_COUNT(CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
        .clk_jt (clk_jt),
        .rst    (rst),
        .mix    (mix)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_gain [CH];
    int m_pan  [CH];
    int m_drop;
    int sl [CH];
    int sr [CH];

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_jt);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_gain[i] = 128;
            m_pan[i]  = 3;
        end
        m_drop = 0;
    endtask

    task automatic model_cfg(input int addr, input int data);
        int chip;
        chip = addr & 31;
        if (chip < CH) begin
            if ((addr & 32) != 0) m_pan[chip] = data & 3;
            else                  m_gain[chip] = data & 255;
        end
    endtask

    // Expected side output. A write taking effect at edge wedge after the
    // strobe edge is seen by chip i only if wedge <= i.
    task automatic expect_side(input bit right, input int waddr, input int wdata,
                               input int wedge, output longint o, output longint clip);
        longint acc;
        longint q;
        int g;
        int p;
        acc = 0;
        for (int i = 0; i < CH; i++) begin
            g = m_gain[i];
            p = m_pan[i];
            if (wedge >= 1 && wedge <= i && (waddr & 31) == i) begin
                if ((waddr & 32) != 0) p = wdata & 3;
                else                   g = wdata & 255;
            end
            if (right ? p[1] : p[0])
                acc += longint'(right ? sr[i] : sl[i]) * longint'(g);
        end
        q = acc / UNITY;
        if (acc < 0 && (acc % UNITY) != 0) q = q - 1;
        clip = 0;
        if (q > 32767) begin o = 32767; clip = 1; end
        else if (q < -32768) begin o = -32768; clip = 1; end
        else o = q;
    endtask

    task automatic cfg_write(input int addr, input int data);
        mix.cfg_we   = 1'b1;
        mix.cfg_addr = 6'(addr);
        mix.cfg_data = GAIN_W'(data);
        step();
        mix.cfg_we   = 1'b0;
        model_cfg(addr, data);
    endtask

    task automatic load_buses();
        for (int i = 0; i < CH; i++) begin
            mix.snd_left_bus[i*IN_W +: IN_W]  = IN_W'(sl[i]);
            mix.snd_right_bus[i*IN_W +: IN_W] = IN_W'(sr[i]);
        end
    endtask

    task automatic set_all(input int l, input int r);
        for (int i = 0; i < CH; i++) begin
            sl[i] = l;
            sr[i] = r;
        end
    endtask

    task automatic randomize_samples();
        for (int i = 0; i < CH; i++) begin
            sl[i] = int'($urandom_range(0, 65535)) - 32768;
            sr[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // One full transaction. wr_edge/dup_edge < 1 disable the mid-sequence
    // config write and the extra strobe respectively.
    task automatic do_sample(input string tag, input int wr_edge, input int wr_addr,
                             input int wr_data, input int dup_edge);
        longint el, er, cl, cr;
        int lat;
        bit seen;
        logic [7:0] busy_mask;
        int extra;
        expect_side(1'b0, wr_addr, wr_data, wr_edge, el, cl);
        expect_side(1'b1, wr_addr, wr_data, wr_edge, er, cr);
        load_buses();
        mix.snd_sample = 1'b1;
        step();
        mix.snd_sample = 1'b0;
        seen = 1'b0;
        lat = -1;
        busy_mask = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (k < 8) busy_mask[k] = mix.busy;
            if (mix.out_valid) begin
                seen = 1'b1;
                lat = k;
            end else begin
                mix.snd_sample = (k + 1 == dup_edge);
                if (k + 1 == wr_edge) begin
                    mix.cfg_we   = 1'b1;
                    mix.cfg_addr = 6'(wr_addr);
                    mix.cfg_data = GAIN_W'(wr_data);
                end else begin
                    mix.cfg_we = 1'b0;
                end
                step();
            end
        end
        mix.snd_sample = 1'b0;
        mix.cfg_we = 1'b0;
        if (wr_edge >= 1) model_cfg(wr_addr, wr_data);
        if (dup_edge >= 1 && dup_edge <= 6 && m_drop < 255) m_drop++;

        chk({tag, "_latency"}, lat, 7);
        chk({tag, "_busy"}, busy_mask, 8'h3F);
        chk({tag, "_left"}, mix.out_left, el);
        chk({tag, "_right"}, mix.out_right, er);
        chk({tag, "_clip_l"}, mix.clip_l, cl);
        chk({tag, "_clip_r"}, mix.clip_r, cr);
        chk({tag, "_drop"}, mix.drop_cnt, m_drop);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mix.out_valid) extra++;
        end
        chk({tag, "_extra_valid"}, extra, 0);
        chk({tag, "_hold_left"}, mix.out_left, el);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_left"}, mix.out_left, 0);
        chk({tag, "_out_right"}, mix.out_right, 0);
        chk({tag, "_out_valid"}, mix.out_valid, 0);
        chk({tag, "_clip_l"}, mix.clip_l, 0);
        chk({tag, "_clip_r"}, mix.clip_r, 0);
        chk({tag, "_busy"}, mix.busy, 0);
        chk({tag, "_drop"}, mix.drop_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        rst = 1'b1;
        mix.snd_sample    = 1'b0;
        mix.snd_left_bus  = '0;
        mix.snd_right_bus = '0;
        mix.cfg_we        = 1'b0;
        mix.cfg_addr      = '0;
        mix.cfg_data      = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        check_reset_state("reset");

        // Basic mix at unity gain.
        set_all(1000, -1000);
        do_sample("basic", -1, 0, 0, -1);

        // Saturation both ways, then back to silence.
        set_all(32767, -32768);
        do_sample("sat", -1, 0, 0, -1);
        set_all(0, 0);
        do_sample("zero", -1, 0, 0, -1);

        // Gain scaling and floor rounding on chip 0.
        cfg_write(6'h00, 8'h40);
        sl[0] = 1000; sr[0] = 1000;
        do_sample("gain40", -1, 0, 0, -1);
        cfg_write(6'h00, 8'hFF);
        sl[0] = 128; sr[0] = -128;
        do_sample("gainFF", -1, 0, 0, -1);
        cfg_write(6'h00, 8'h40);
        sl[0] = -1; sr[0] = -1;
        do_sample("floor", -1, 0, 0, -1);

        // Chip 1 gain cleared after chip 1 was accumulated, then before.
        randomize_samples();
        do_sample("late_wr", 3, 6'h01, 8'h00, -1);
        do_sample("late_wr_next", -1, 0, 0, -1);
        randomize_samples();
        do_sample("early_wr", 1, 6'h03, 8'h20, -1);

        // Pan: chip 2 left only; out-of-range addresses change nothing.
        set_all(0, 0);
        sl[2] = 2000; sr[2] = 2000;
        cfg_write(6'h22, 2'b01);
        do_sample("pan", -1, 0, 0, -1);
        cfg_write(6'h05, 8'h00);
        cfg_write(6'h25, 8'h00);
        do_sample("oor", -1, 0, 0, -1);

        // Dropped strobes, then saturation of the counter under random data.
        randomize_samples();
        do_sample("drop1", -1, 0, 0, 3);
        for (int n = 0; n < 300; n++) begin
            randomize_samples();
            do_sample("drop_sat", -1, 0, 0, int'($urandom_range(1, 6)));
        end

        // Random gains and pans.
        for (int n = 0; n < 20; n++) begin
            cfg_write(int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
            cfg_write(32 + int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            randomize_samples();
            do_sample("rand", -1, 0, 0, -1);
        end

        // Reset in the middle of accumulation.
        cfg_write(6'h00, 8'h10);
        set_all(3000, -3000);
        do_sample("pre_rst", -1, 0, 0, -1);
        load_buses();
        mix.snd_sample = 1'b1;
        step();
        mix.snd_sample = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_reset_state("mid_rst");
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (mix.out_valid) extra++;
        end
        chk("mid_rst_no_valid", extra, 0);
        randomize_samples();
        do_sample("post_rst", -1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
